// File: rtl/booth_entry_ctrl.sv
// Sequencing controller between the keypad decoder and the operand-entry / Booth
// multiplier datapath: key filtering, operand select, launch, timeout, result hold.
module booth_entry_ctrl #(
    parameter int MAX_DIGITS   = 3,
    parameter int DONE_TIMEOUT = 64,
    parameter int RESULT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_pressed,
    input  logic [3:0]          key_value,
    input  logic                is_sign_key,
    input  logic                mul_done,
    input  logic [RESULT_W-1:0] mul_result,
    output logic                key_pressed_fwd,
    output logic [3:0]          key_value_fwd,
    output logic                is_sign_key_fwd,
    output logic                state_enableA,
    output logic                state_enableB,
    output logic                mul_start,
    output logic [RESULT_W-1:0] result_q,
    output logic                result_valid,
    output logic                timeout_err,
    output logic [2:0]          state_dbg,
    output logic [1:0]          digit_count
);
    localparam int               CNT_W       = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [1:0]       DIGIT_MAX   = 2'(MAX_DIGITS);
    localparam logic [3:0]       KEY_CLEAR   = 4'hA;
    localparam logic [3:0]       KEY_CONFIRM = 4'hB;

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_SHOW    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                key_prev_q, key_prev_d;
    logic [1:0]          digit_cnt_q, digit_cnt_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [1:0]          clr_cnt_q, clr_cnt_d;
    logic                fwd_q, fwd_d;
    logic [3:0]          fwd_val_q, fwd_val_d;
    logic                fwd_sign_q, fwd_sign_d;
    logic [RESULT_W-1:0] result_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic key_event;
    logic is_digit;
    logic is_clear;
    logic is_confirm;

    // Rising edge of the keypad strobe; swallowed while a synthetic clear is on the bus.
    assign key_event  = key_pressed & ~key_prev_q & (clr_cnt_q == 2'd0);
    assign is_digit   = ~is_sign_key & (key_value <= 4'd9);
    assign is_clear   = is_sign_key & (key_value == KEY_CLEAR);
    assign is_confirm = is_sign_key & (key_value == KEY_CONFIRM);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        key_prev_d  = key_pressed;
        digit_cnt_d = digit_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        clr_cnt_d   = clr_cnt_q;
        fwd_d       = fwd_q & key_pressed;
        fwd_val_d   = fwd_val_q;
        fwd_sign_d  = fwd_sign_q;
        result_d    = result_q;
        valid_d     = valid_q;
        err_d       = err_q;

        if (clr_cnt_q != 2'd0) begin
            clr_cnt_d = clr_cnt_q - 2'd1;
            fwd_d     = (clr_cnt_q == 2'd2);
        end

        case (state_q)
            S_ENTER_A, S_ENTER_B: begin
                if (key_event) begin
                    if (is_digit) begin
                        if (digit_cnt_q < DIGIT_MAX) begin
                            fwd_d       = 1'b1;
                            fwd_val_d   = key_value;
                            fwd_sign_d  = is_sign_key;
                            digit_cnt_d = digit_cnt_q + 2'd1;
                        end
                    end else if (is_clear) begin
                        fwd_d       = 1'b1;
                        fwd_val_d   = key_value;
                        fwd_sign_d  = is_sign_key;
                        digit_cnt_d = 2'd0;
                        state_d     = S_ENTER_A;
                    end else if (is_confirm && (digit_cnt_q != 2'd0)) begin
                        if (state_q == S_ENTER_A) begin
                            digit_cnt_d = 2'd0;
                            state_d     = S_ENTER_B;
                        end else begin
                            state_d = S_START;
                        end
                    end
                end
            end
            S_START: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the expiry cycle still counts as a success.
                if (mul_done) begin
                    result_d = mul_result;
                    valid_d  = 1'b1;
                    state_d  = S_SHOW;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    result_d = '0;
                    valid_d  = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_SHOW;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            S_SHOW: begin
                if (key_event) begin
                    valid_d     = 1'b0;
                    err_d       = 1'b0;
                    digit_cnt_d = 2'd0;
                    clr_cnt_d   = 2'd2;
                    fwd_d       = 1'b1;
                    fwd_val_d   = KEY_CLEAR;
                    fwd_sign_d  = 1'b1;
                    state_d     = S_ENTER_A;
                end
            end
            default: state_d = S_ENTER_A;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_ENTER_A;
            key_prev_q  <= 1'b0;
            digit_cnt_q <= 2'd0;
            tmo_cnt_q   <= '0;
            clr_cnt_q   <= 2'd0;
            fwd_q       <= 1'b0;
            fwd_val_q   <= 4'd0;
            fwd_sign_q  <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_prev_q  <= key_prev_d;
            digit_cnt_q <= digit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            clr_cnt_q   <= clr_cnt_d;
            fwd_q       <= fwd_d;
            fwd_val_q   <= fwd_val_d;
            fwd_sign_q  <= fwd_sign_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign key_pressed_fwd = fwd_q;
    assign key_value_fwd   = fwd_val_q;
    assign is_sign_key_fwd = fwd_sign_q;
    assign state_enableA   = (state_q == S_ENTER_A);
    assign state_enableB   = (state_q == S_ENTER_B);
    assign mul_start       = (state_q == S_START);
    assign result_valid    = valid_q;
    assign timeout_err     = err_q;
    assign state_dbg       = state_q;
    assign digit_count     = digit_cnt_q;

endmodule

// File: tb/tb_booth_entry_ctrl.sv
// Directed bench for booth_entry_ctrl: a behavioural model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_booth_entry_ctrl;
    localparam int MAX_DIGITS   = 3;
    localparam int DONE_TIMEOUT = 64;
    localparam int RESULT_W     = 16;

    logic                clk;
    logic                rst;
    logic                key_pressed;
    logic [3:0]          key_value;
    logic                is_sign_key;
    logic                mul_done;
    logic [RESULT_W-1:0] mul_result;
    logic                key_pressed_fwd;
    logic [3:0]          key_value_fwd;
    logic                is_sign_key_fwd;
    logic                state_enableA;
    logic                state_enableB;
    logic                mul_start;
    logic [RESULT_W-1:0] result_q;
    logic                result_valid;
    logic                timeout_err;
    logic [2:0]          state_dbg;
    logic [1:0]          digit_count;

    int vectors     = 0;
    int miscompares = 0;
    int fwd_pulses  = 0;
    int start_cycles = 0;
    bit fwd_seen    = 1'b0;

    booth_entry_ctrl #(
        .MAX_DIGITS  (MAX_DIGITS),
        .DONE_TIMEOUT(DONE_TIMEOUT),
        .RESULT_W    (RESULT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_pressed    (key_pressed),
        .key_value      (key_value),
        .is_sign_key    (is_sign_key),
        .mul_done       (mul_done),
        .mul_result     (mul_result),
        .key_pressed_fwd(key_pressed_fwd),
        .key_value_fwd  (key_value_fwd),
        .is_sign_key_fwd(is_sign_key_fwd),
        .state_enableA  (state_enableA),
        .state_enableB  (state_enableB),
        .mul_start      (mul_start),
        .result_q       (result_q),
        .result_valid   (result_valid),
        .timeout_err    (timeout_err),
        .state_dbg      (state_dbg),
        .digit_count    (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 enter A, 1 enter B, 2 launch, 3 waiting, 4 showing result.
    int              m_phase;
    int              m_digits;
    int              m_wait;
    int              m_clear_left;
    bit              m_prev;
    bit              m_fwd;
    bit              m_sign;
    bit              m_valid;
    bit              m_err;
    logic [3:0]      m_val;
    logic [RESULT_W-1:0] m_result;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_digits = 0; m_wait = 0; m_clear_left = 0;
            m_prev = 0; m_fwd = 0; m_sign = 0; m_valid = 0; m_err = 0;
            m_val = 4'd0; m_result = '0;
        end else begin
            bit ev;
            bit accept;
            bit dig;
            bit clr;
            bit conf;
            ev     = key_pressed && !m_prev;
            m_prev = key_pressed;
            m_fwd  = m_fwd && key_pressed;
            accept = ev;
            if (m_clear_left > 0) begin
                m_clear_left = m_clear_left - 1;
                m_fwd  = (m_clear_left > 0);
                accept = 0;
            end
            dig  = !is_sign_key && (key_value <= 4'd9);
            clr  = is_sign_key && (key_value == 4'hA);
            conf = is_sign_key && (key_value == 4'hB);
            case (m_phase)
                0, 1: if (accept) begin
                    if (dig) begin
                        if (m_digits < MAX_DIGITS) begin
                            m_fwd = 1; m_val = key_value; m_sign = 0;
                            m_digits = m_digits + 1;
                        end
                    end else if (clr) begin
                        m_fwd = 1; m_val = 4'hA; m_sign = 1;
                        m_digits = 0; m_phase = 0;
                    end else if (conf && m_digits > 0) begin
                        if (m_phase == 0) begin m_phase = 1; m_digits = 0; end
                        else m_phase = 2;
                    end
                end
                2: begin m_phase = 3; m_wait = 0; end
                3: begin
                    if (mul_done) begin
                        m_result = mul_result; m_valid = 1; m_phase = 4;
                    end else begin
                        m_wait = m_wait + 1;
                        if (m_wait == DONE_TIMEOUT) begin
                            m_result = '0; m_valid = 0; m_err = 1; m_phase = 4;
                        end
                    end
                end
                4: if (accept) begin
                    m_valid = 0; m_err = 0; m_digits = 0;
                    m_clear_left = 2; m_fwd = 1; m_val = 4'hA; m_sign = 1;
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare + pulse monitor ----------------
    always @(negedge clk) begin
        check("state_dbg",       32'(state_dbg),       32'(m_phase));
        check("state_enableA",   32'(state_enableA),   32'(m_phase == 0));
        check("state_enableB",   32'(state_enableB),   32'(m_phase == 1));
        check("mul_start",       32'(mul_start),       32'(m_phase == 2));
        check("key_pressed_fwd", 32'(key_pressed_fwd), 32'(m_fwd));
        check("key_value_fwd",   32'(key_value_fwd),   32'(m_val));
        check("is_sign_key_fwd", 32'(is_sign_key_fwd), 32'(m_sign));
        check("result_q",        32'(result_q),        32'(m_result));
        check("result_valid",    32'(result_valid),    32'(m_valid));
        check("timeout_err",     32'(timeout_err),     32'(m_err));
        check("digit_count",     32'(digit_count),     32'(m_digits));
        if (key_pressed_fwd && !fwd_seen) fwd_pulses++;
        fwd_seen = key_pressed_fwd;
        if (mul_start) start_cycles++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [3:0] val, input logic sign, input int hold);
        key_value   = val;
        is_sign_key = sign;
        key_pressed = 1'b1;
        repeat (hold) step();
        key_pressed = 1'b0;
        repeat (2) step();
    endtask

    task automatic enter_operands(input logic [3:0] a, input logic [3:0] b);
        press(a, 1'b0, 2);
        press(4'hB, 1'b1, 2);
        press(b, 1'b0, 2);
        press(4'hB, 1'b1, 2);
    endtask

    initial begin
        key_pressed = 1'b0;
        key_value   = 4'd0;
        is_sign_key = 1'b0;
        mul_done    = 1'b0;
        mul_result  = 16'hBEEF;
        rst         = 1'b0;
        #2;
        check("rst_state",   32'(state_dbg),       32'd0);
        check("rst_enableA", 32'(state_enableA),   32'd1);
        check("rst_start",   32'(mul_start),       32'd0);
        check("rst_fwd",     32'(key_pressed_fwd), 32'd0);
        check("rst_result",  32'(result_q),        32'd0);
        repeat (3) step();
        rst = 1'b1;
        step();

        // Scenario 1: A = 12, B = 3, product 36 returned after ~10 cycles.
        fwd_pulses = 0; start_cycles = 0;
        press(4'd1, 1'b0, 2);
        check("s1_enA_on_digit", 32'(state_enableA), 32'd1);
        check("s1_fwd_val_1",    32'(key_value_fwd), 32'd1);
        press(4'd2, 1'b0, 2);
        press(4'hB, 1'b1, 2);
        press(4'd3, 1'b0, 2);
        check("s1_enB_on_digit", 32'(state_enableB), 32'd1);
        check("s1_enA_off",      32'(state_enableA), 32'd0);
        press(4'hB, 1'b1, 2);
        repeat (6) step();
        mul_done = 1'b1; mul_result = 16'd36;
        step();
        mul_done = 1'b0; mul_result = 16'hBEEF;
        check("s1_result",     32'(result_q),     32'd36);
        check("s1_valid",      32'(result_valid), 32'd1);
        check("s1_state_show", 32'(state_dbg),    32'd4);
        check("s1_fwd_count",  32'(fwd_pulses),   32'd3);
        check("s1_one_start",  32'(start_cycles), 32'd1);

        // Scenario 2: digit in SHOW is consumed, synthetic clear for 2 cycles.
        fwd_pulses = 0;
        key_value = 4'd9; is_sign_key = 1'b0; key_pressed = 1'b1;
        step();
        check("s2_clr_fwd1",  32'(key_pressed_fwd), 32'd1);
        check("s2_clr_val",   32'(key_value_fwd),   32'hA);
        check("s2_clr_sign",  32'(is_sign_key_fwd), 32'd1);
        check("s2_state_a",   32'(state_dbg),       32'd0);
        check("s2_valid_off", 32'(result_valid),    32'd0);
        step();
        check("s2_clr_fwd2",  32'(key_pressed_fwd), 32'd1);
        step();
        check("s2_clr_end",   32'(key_pressed_fwd), 32'd0);
        key_pressed = 1'b0;
        repeat (2) step();
        check("s2_one_strobe", 32'(fwd_pulses), 32'd1);
        check("s2_result_held", 32'(result_q),  32'd36);

        // Scenario 3: fourth digit dropped.
        fwd_pulses = 0;
        press(4'd1, 1'b0, 2);
        press(4'd2, 1'b0, 2);
        press(4'd3, 1'b0, 2);
        key_value = 4'd4; is_sign_key = 1'b0; key_pressed = 1'b1;
        step();
        check("s3_4th_no_fwd", 32'(key_pressed_fwd), 32'd0);
        step();
        key_pressed = 1'b0;
        repeat (2) step();
        check("s3_fwd_count", 32'(fwd_pulses),    32'd3);
        check("s3_digits",    32'(digit_count),   32'd3);
        check("s3_last_val",  32'(key_value_fwd), 32'd3);
        press(4'hA, 1'b1, 2);
        check("s3_clear_digits", 32'(digit_count),   32'd0);
        check("s3_clear_val",    32'(key_value_fwd), 32'hA);

        // Scenario 4: confirm with no digits is ignored.
        fwd_pulses = 0;
        press(4'hB, 1'b1, 2);
        check("s4_state_a", 32'(state_dbg),  32'd0);
        check("s4_no_fwd",  32'(fwd_pulses), 32'd0);

        // Scenario 5: A = 5, B = 7, no completion -> timeout after 64 WAIT cycles.
        enter_operands(4'd5, 4'd7);
        repeat (61) step();
        check("s5_still_wait", 32'(state_dbg),   32'd3);
        check("s5_no_err_yet", 32'(timeout_err), 32'd0);
        step();
        check("s5_state_show", 32'(state_dbg),    32'd4);
        check("s5_timeout",    32'(timeout_err),  32'd1);
        check("s5_valid",      32'(result_valid), 32'd0);
        check("s5_result",     32'(result_q),     32'd0);

        // Scenario 6: completion lands on the expiry cycle -> done wins.
        press(4'd0, 1'b0, 2);
        check("s6_err_cleared", 32'(timeout_err), 32'd0);
        enter_operands(4'd5, 4'd7);
        repeat (61) step();
        check("s6_still_wait", 32'(state_dbg), 32'd3);
        mul_done = 1'b1; mul_result = 16'd35;
        step();
        mul_done = 1'b0; mul_result = 16'hBEEF;
        check("s6_state_show", 32'(state_dbg),    32'd4);
        check("s6_result",     32'(result_q),     32'd35);
        check("s6_valid",      32'(result_valid), 32'd1);
        check("s6_no_timeout", 32'(timeout_err),  32'd0);

        // Scenario 7: reset mid-WAIT, then a single press is detected once.
        press(4'd1, 1'b0, 2);
        enter_operands(4'd2, 4'd3);
        repeat (3) step();
        check("s7_in_wait", 32'(state_dbg), 32'd3);
        rst = 1'b0;
        #1;
        start_cycles = 0;
        check("s7_rst_state",   32'(state_dbg),     32'd0);
        check("s7_rst_start",   32'(mul_start),     32'd0);
        check("s7_rst_enA",     32'(state_enableA), 32'd1);
        check("s7_rst_result",  32'(result_q),      32'd0);
        check("s7_rst_valid",   32'(result_valid),  32'd0);
        check("s7_rst_digits",  32'(digit_count),   32'd0);
        repeat (2) step();
        rst = 1'b1;
        step();
        fwd_pulses = 0;
        press(4'd6, 1'b0, 3);
        check("s7_once_fwd",    32'(fwd_pulses),    32'd1);
        check("s7_once_digits", 32'(digit_count),   32'd1);
        check("s7_once_val",    32'(key_value_fwd), 32'd6);
        mul_done = 1'b1; mul_result = 16'd99;
        step();
        mul_done = 1'b0; mul_result = 16'hBEEF;
        step();
        check("s7_done_ignored", 32'(result_valid), 32'd0);
        check("s7_result_kept",  32'(result_q),     32'd0);
        check("s7_no_restart",   32'(start_cycles), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
